// File: rtl/user_upd_reg.sv
// JTAG user-data update register: serial-in, parallel-out behind a BSCAN user instruction.
// Define USER_UPD_LEN_CHK_EN to reject updates whose scan length is not exactly WIDTH bits.
module user_upd_reg #(
  parameter int              WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             DRCK,
  input  logic             RST_N,
  input  logic             SEL,
  input  logic             CAPTURE,
  input  logic             SHIFT,
  input  logic             UPDATE,
  input  logic             TDI,
  output logic             TDO,
  output logic [WIDTH-1:0] PAR_OUT,
  output logic             UPD_STB,
  output logic             LEN_ERR
);

  typedef enum logic {IDLE = 1'b0, SHIFTING = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] par_d;
  logic             stb_d;
  logic             accept;

  assign TDO = SEL & sr_q[0];

  // Priority among the TAP indicators is UPDATE, then CAPTURE, then SHIFT.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    par_d   = PAR_OUT;
    stb_d   = 1'b0;
    if (SEL) begin
      if (UPDATE) begin
        if (state_q == SHIFTING) begin
          if (accept) begin
            par_d = sr_q;
            stb_d = 1'b1;
          end
          state_d = IDLE;
        end
      end else if (CAPTURE) begin
        sr_d    = PAR_OUT;
        state_d = SHIFTING;
      end else if (SHIFT) begin
        sr_d = {TDI, sr_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge DRCK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      sr_q    <= '0;
      PAR_OUT <= RST_VAL;
      UPD_STB <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      PAR_OUT <= par_d;
      UPD_STB <= stb_d;
    end
  end

`ifdef USER_UPD_LEN_CHK_EN
  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  assign accept  = (cnt_q == CNT_FULL);
  assign LEN_ERR = err_q;

  // Counter saturates one past WIDTH so overlong scans stay distinguishable.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (SEL) begin
      if (UPDATE) begin
        if (state_q == SHIFTING && !accept) err_d = 1'b1;
      end else if (CAPTURE) begin
        cnt_d = '0;
        err_d = 1'b0;
      end else if (SHIFT && state_q == SHIFTING && cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge DRCK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`else
  assign accept  = 1'b1;
  assign LEN_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_user_upd_reg.sv
// Randomised and directed bench for user_upd_reg against a queue-based scan model.
module tb_user_upd_reg;
  localparam int         W    = 8;
  localparam logic [7:0] RSTV = 8'h96;

  logic       DRCK = 1'b0;
  logic       RST_N = 1'b1;
  logic       SEL = 1'b0, CAPTURE = 1'b0, SHIFT = 1'b0, UPDATE = 1'b0, TDI = 1'b0;
  logic       TDO;
  logic [7:0] PAR_OUT;
  logic       UPD_STB, LEN_ERR;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  user_upd_reg #(.WIDTH(W), .RST_VAL(RSTV)) dut (
    .DRCK(DRCK), .RST_N(RST_N), .SEL(SEL), .CAPTURE(CAPTURE), .SHIFT(SHIFT),
    .UPDATE(UPDATE), .TDI(TDI), .TDO(TDO), .PAR_OUT(PAR_OUT), .UPD_STB(UPD_STB),
    .LEN_ERR(LEN_ERR)
  );

  always #5 DRCK = ~DRCK;

  // Model: the scan chain is a FIFO of bits, front = bit presented on TDO.
  bit         m_q[$];
  logic [7:0] m_par = RSTV;
  int         m_bits = 0;
  bit         m_shifting = 0, m_stb = 0, m_err = 0;

  function automatic logic [7:0] q_word();
    logic [7:0] w;
    for (int i = 0; i < W; i++) w[i] = m_q[i];
    return w;
  endfunction

  function automatic bit len_ok();
`ifdef USER_UPD_LEN_CHK_EN
    return m_bits == W;
`else
    return 1'b1;
`endif
  endfunction

  always @(posedge DRCK or negedge RST_N) begin
    if (!RST_N) begin
      m_q.delete();
      for (int i = 0; i < W; i++) m_q.push_back(1'b0);
      m_par = RSTV; m_bits = 0; m_shifting = 0; m_stb = 0; m_err = 0;
    end else begin
      m_stb = 0;
      if (SEL) begin
        if (UPDATE) begin
          if (m_shifting) begin
            if (len_ok()) begin
              m_par = q_word();
              m_stb = 1;
            end else begin
              m_err = 1;
            end
            m_shifting = 0;
          end
        end else if (CAPTURE) begin
          m_q.delete();
          for (int i = 0; i < W; i++) m_q.push_back(m_par[i]);
          m_bits = 0; m_shifting = 1; m_err = 0;
        end else if (SHIFT) begin
          void'(m_q.pop_front());
          m_q.push_back(TDI);
          if (m_shifting) m_bits++;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge DRCK) begin
    if (chk_en) begin
      checkOutput("model_tdo", 64'(TDO), 64'(SEL & m_q[0]));
      checkOutput("model_par", 64'(PAR_OUT), 64'(m_par));
      checkOutput("model_stb", 64'(UPD_STB), 64'(m_stb));
      checkOutput("model_err", 64'(LEN_ERR), 64'(m_err));
    end
  end

  task automatic applyStimulus(input bit sel, input bit cap, input bit shf, input bit upd, input bit tdi);
    SEL = sel; CAPTURE = cap; SHIFT = shf; UPDATE = upd; TDI = tdi;
    @(posedge DRCK);
    #1;
  endtask

  task automatic pulseReset();
    RST_N = 1'b0;
    #2;
    RST_N = 1'b1;
  endtask

  // Shifts n bits of val LSB first; returns the TDO bit seen before each edge.
  task automatic scanBits(input logic [15:0] val, input int n, output logic [15:0] seen);
    seen = '0;
    for (int i = 0; i < n; i++) begin
      seen[i] = TDO;
      applyStimulus(1, 0, 1, 0, val[i]);
    end
  endtask

  logic [15:0] seen;
  logic [7:0]  par_now;

  initial begin
    #1 RST_N = 1'b0;
    repeat (3) applyStimulus(0, 0, 0, 0, 0);
    chk_en = 1;
    checkOutput("reset_par", 64'(PAR_OUT), 64'(RSTV));
    checkOutput("reset_stb", 64'(UPD_STB), 64'd0);
    checkOutput("reset_err", 64'(LEN_ERR), 64'd0);
    checkOutput("reset_tdo", 64'(TDO), 64'd0);
    RST_N = 1'b1;

    applyStimulus(1, 1, 0, 0, 0);
    scanBits(16'h0000, 8, seen);
    checkOutput("readback_tdo", 64'(seen[7:0]), 64'(RSTV));
    checkOutput("readback_par", 64'(PAR_OUT), 64'(RSTV));

    applyStimulus(1, 1, 0, 0, 0);
    scanBits(16'h00A5, 8, seen);
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("load_a5_par", 64'(PAR_OUT), 64'hA5);
    checkOutput("load_a5_stb", 64'(UPD_STB), 64'd1);
    checkOutput("load_a5_err", 64'(LEN_ERR), 64'd0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("stb_one_edge", 64'(UPD_STB), 64'd0);

    applyStimulus(1, 1, 0, 0, 0);
    scanBits(16'h003C, 8, seen);
    checkOutput("shiftout_a5", 64'(seen[7:0]), 64'hA5);
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("load_3c_par", 64'(PAR_OUT), 64'h3C);

    applyStimulus(1, 1, 0, 0, 0);
    scanBits(16'h001F, 5, seen);
    applyStimulus(1, 0, 0, 1, 0);
`ifdef USER_UPD_LEN_CHK_EN
    checkOutput("short_par", 64'(PAR_OUT), 64'h3C);
    checkOutput("short_stb", 64'(UPD_STB), 64'd0);
    checkOutput("short_err", 64'(LEN_ERR), 64'd1);
    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("capture_clears_err", 64'(LEN_ERR), 64'd0);
    par_now = 8'h3C;
`else
    checkOutput("short_par", 64'(PAR_OUT), 64'hF9);
    checkOutput("short_stb", 64'(UPD_STB), 64'd1);
    checkOutput("short_err", 64'(LEN_ERR), 64'd0);
    par_now = 8'hF9;
`endif

    applyStimulus(1, 1, 0, 0, 0);
    scanBits(16'h05C3, 12, seen);
    applyStimulus(1, 0, 0, 1, 0);
`ifdef USER_UPD_LEN_CHK_EN
    checkOutput("long_par", 64'(PAR_OUT), 64'(par_now));
    checkOutput("long_err", 64'(LEN_ERR), 64'd1);
`else
    checkOutput("long_par", 64'(PAR_OUT), 64'h5C);
    checkOutput("long_err", 64'(LEN_ERR), 64'd0);
`endif

    applyStimulus(1, 1, 0, 0, 0);
    scanBits(16'h000F, 4, seen);
    pulseReset();
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("midreset_par", 64'(PAR_OUT), 64'(RSTV));
    checkOutput("midreset_stb", 64'(UPD_STB), 64'd0);

    applyStimulus(0, 1, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 0, 1, 0, 1);
      checkOutput("desel_tdo", 64'(TDO), 64'd0);
    end
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("desel_par", 64'(PAR_OUT), 64'(RSTV));
    checkOutput("desel_stb", 64'(UPD_STB), 64'd0);
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("stray_upd_stb", 64'(UPD_STB), 64'd0);
    checkOutput("stray_upd_par", 64'(PAR_OUT), 64'(RSTV));

    // Structured random scans with injected noise on the control lines.
    for (int s = 0; s < 60; s++) begin
      applyStimulus($urandom_range(0, 9) != 0, 1, $urandom_range(0, 1), $urandom_range(0, 7) == 0, $urandom_range(0, 1));
      for (int i = 0, n = $urandom_range(6, 10); i < n; i++)
        applyStimulus($urandom_range(0, 15) != 0, $urandom_range(0, 19) == 0, 1, 0, $urandom_range(0, 1));
      applyStimulus($urandom_range(0, 15) != 0, $urandom_range(0, 3) == 0, 0, 1, 0);
      if ($urandom_range(0, 19) == 0) pulseReset();
    end
    for (int i = 0; i < 300; i++)
      applyStimulus($urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0,
                    $urandom_range(0, 9) == 0, $urandom_range(0, 1));

    applyStimulus(0, 0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
